// File: rtl/framebuffer_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// framebuffer_scanout: 640x480@60 VGA timing, 2x pixel-doubled frame-buffer scanout, front/back buffer selection.
// Rev 1.0
module framebuffer_scanout #(
  parameter int unsigned H_OFS        = 80,
  parameter int unsigned V_OFS        = 80,
  parameter int unsigned SRC_W        = 240,
  parameter int unsigned SRC_H        = 160,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_END   = 752,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_SYNC_END   = 492,
  parameter int unsigned V_TOTAL      = 525
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_ready,
  output logic        rd_sel,
  output logic        rd_en,
  output logic [16:0] rd_addr,
  input  logic [14:0] rd_data,
  output logic [4:0]  VGA_R,
  output logic [4:0]  VGA_G,
  output logic [4:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        vblank,
  output logic        frame_start
);

  localparam logic [9:0]  C_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  C_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  C_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  C_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  C_HS_LO  = 10'(H_SYNC_START);
  localparam logic [9:0]  C_HS_HI  = 10'(H_SYNC_END);
  localparam logic [9:0]  C_VS_LO  = 10'(V_SYNC_START);
  localparam logic [9:0]  C_VS_HI  = 10'(V_SYNC_END);
  localparam logic [9:0]  C_WH_LO  = 10'(H_OFS);
  localparam logic [9:0]  C_WH_HI  = 10'(H_OFS + 2 * SRC_W);
  localparam logic [9:0]  C_WV_LO  = 10'(V_OFS);
  localparam logic [9:0]  C_WV_HI  = 10'(V_OFS + 2 * SRC_H);
  localparam logic [9:0]  C_SWAP_V = 10'(V_ACTIVE - 1);
  localparam logic [16:0] C_SRC_W  = 17'(SRC_W);

  logic [9:0]  h_cnt, v_cnt, h_next, v_next;
  logic        h_last, v_last, in_win_h, in_win_v, window, active, hs_n, vs_n;
  logic        v_odd, swap_now, pending;
  logic [8:0]  h_pix;
  logic [16:0] line_base, pix_addr;

  // Pipe entry bits: {window, active, hs_n, vs_n}; entry 0 is aligned with rd_addr.
  logic [3:0]  pipe [0:READ_LAT];
  logic [3:0]  dly;

  always_comb begin
    h_last   = (h_cnt == C_H_LAST);
    v_last   = (v_cnt == C_V_LAST);
    h_next   = h_last ? 10'd0 : h_cnt + 10'd1;
    v_next   = h_last ? (v_last ? 10'd0 : v_cnt + 10'd1) : v_cnt;
    in_win_h = (h_cnt >= C_WH_LO) && (h_cnt < C_WH_HI);
    in_win_v = (v_cnt >= C_WV_LO) && (v_cnt < C_WV_HI);
    window   = in_win_h && in_win_v;
    active   = (h_cnt < C_H_ACT) && (v_cnt < C_V_ACT);
    hs_n     = !((h_cnt >= C_HS_LO) && (h_cnt < C_HS_HI));
    vs_n     = !((v_cnt >= C_VS_LO) && (v_cnt < C_VS_HI));
    // Bit 0 of (v - V_OFS) without a subtractor.
    v_odd    = v_cnt[0] ^ C_WV_LO[0];
    h_pix    = 9'((h_cnt - C_WH_LO) >> 1);
    pix_addr = line_base + {8'd0, h_pix};
    swap_now = h_last && (v_cnt == C_SWAP_V);
    dly      = pipe[READ_LAT];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_base   <= '0;
      rd_sel      <= 1'b0;
      pending     <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      vblank      <= (v_next >= C_V_ACT);
      frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
      if (h_last && v_last) begin
        line_base <= '0;
      end else if (h_last && in_win_v && v_odd) begin
        line_base <= line_base + C_SRC_W;
      end
      rd_en <= window;
      if (window) begin
        rd_addr <= pix_addr;
      end
      // Swapping only on entry to vertical blank keeps the displayed buffer stable mid-frame.
      if (swap_now && (pending || frame_ready)) begin
        rd_sel  <= ~rd_sel;
        pending <= 1'b0;
      end else if (frame_ready) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= READ_LAT; i++) begin
        pipe[i] <= 4'b0011;
      end
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else begin
      pipe[0] <= {window, active, hs_n, vs_n};
      for (int i = 1; i <= READ_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
      if (dly[3] && dly[2]) begin
        VGA_R <= rd_data[4:0];
        VGA_G <= rd_data[9:5];
        VGA_B <= rd_data[14:10];
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
      VGA_HS <= dly[1];
      VGA_VS <= dly[0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// tb_framebuffer_scanout: compact-timing DUT checked cycle-by-cycle against a frame model,
// plus a default-parameter DUT for the real 640x480 horizontal sync timing.
module tb_framebuffer_scanout;

  localparam int P_HO = 4, P_VO = 3, P_SW = 8, P_SH = 6;
  localparam int P_HA = 24, P_HSS = 26, P_HSE = 30, P_HT = 32;
  localparam int P_VA = 16, P_VSS = 17, P_VSE = 18, P_VT = 20;

  logic        clk, reset, frame_ready;
  logic        a_sel, a_en, a_hs, a_vs, a_vb, a_fs;
  logic [16:0] a_addr;
  logic [14:0] a_data;
  logic [4:0]  a_r, a_g, a_b;
  logic        b_sel, b_en, b_hs, b_vs, b_vb, b_fs;
  logic [16:0] b_addr;
  logic [14:0] b_data;
  logic [4:0]  b_r, b_g, b_b;

  logic [14:0] mem0 [0:63];
  logic [14:0] mem1 [0:63];

  framebuffer_scanout #(
    .H_OFS(P_HO), .V_OFS(P_VO), .SRC_W(P_SW), .SRC_H(P_SH), .READ_LAT(1),
    .H_ACTIVE(P_HA), .H_SYNC_START(P_HSS), .H_SYNC_END(P_HSE), .H_TOTAL(P_HT),
    .V_ACTIVE(P_VA), .V_SYNC_START(P_VSS), .V_SYNC_END(P_VSE), .V_TOTAL(P_VT)
  ) dut_a (
    .clock(clk), .reset(reset), .frame_ready(frame_ready), .rd_sel(a_sel), .rd_en(a_en),
    .rd_addr(a_addr), .rd_data(a_data), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .vblank(a_vb), .frame_start(a_fs)
  );

  framebuffer_scanout dut_b (
    .clock(clk), .reset(reset), .frame_ready(1'b0), .rd_sel(b_sel), .rd_en(b_en),
    .rd_addr(b_addr), .rd_data(b_data), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .vblank(b_vb), .frame_start(b_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read latency frame buffer for DUT A.
  always @(posedge clk) a_data <= a_sel ? mem1[a_addr[5:0]] : mem0[a_addr[5:0]];
  assign b_data = 15'h7FFF;

  int  checks = 0, errors = 0;
  int  k, last_addr;
  int  mh [4];
  int  mv [4];
  bit  msel [4];
  bit  pend, en_exp;
  bit  track_b, b_prev;
  int  b_n;
  int  b_fall [2];

  function automatic bit win_f(input int h, input int v);
    return (h >= P_HO) && (h < P_HO + 2*P_SW) && (v >= P_VO) && (v < P_VO + 2*P_SH);
  endfunction

  function automatic int addr_f(input int h, input int v);
    return ((v - P_VO) / 2) * P_SW + (h - P_HO) / 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d k=%0d", tag, obs, exp_v, k);
    end
  endtask

  task automatic model_step(input bit fr, input bit rs);
    int nh, nv;
    bit nsel;
    if (rs) begin
      k = 0; pend = 0; last_addr = 0; en_exp = 0;
      for (int i = 0; i < 4; i++) begin mh[i] = 0; mv[i] = 0; msel[i] = 0; end
    end else begin
      nh = (mh[0] + 1) % P_HT;
      nv = (nh == 0) ? (mv[0] + 1) % P_VT : mv[0];
      nsel = msel[0];
      if (mh[0] == P_HT-1 && mv[0] == P_VA-1) begin
        if (pend || fr) begin nsel = !nsel; pend = 0; end
      end else if (fr) begin
        pend = 1;
      end
      en_exp = win_f(mh[0], mv[0]);
      if (en_exp) last_addr = addr_f(mh[0], mv[0]);
      for (int i = 3; i > 0; i--) begin mh[i] = mh[i-1]; mv[i] = mv[i-1]; msel[i] = msel[i-1]; end
      mh[0] = nh; mv[0] = nv; msel[0] = nsel;
      k++;
    end
  endtask

  task automatic compare();
    logic [14:0] px;
    bit e_hs, e_vs;
    px = '0; e_hs = 1; e_vs = 1;
    if (k >= 3) begin
      e_hs = !(mh[3] >= P_HSS && mh[3] < P_HSE);
      e_vs = !(mv[3] >= P_VSS && mv[3] < P_VSE);
      if (win_f(mh[3], mv[3]))
        px = msel[2] ? mem1[addr_f(mh[3], mv[3])] : mem0[addr_f(mh[3], mv[3])];
    end
    chk("rd_sel", a_sel, msel[0]);
    chk("rd_en", a_en, en_exp);
    chk("rd_addr", a_addr, last_addr);
    chk("vblank", a_vb, mv[0] >= P_VA);
    chk("frame_start", a_fs, (k >= 1) && mh[0] == 0 && mv[0] == 0);
    chk("hs", a_hs, e_hs);
    chk("vs", a_vs, e_vs);
    chk("red", a_r, px[4:0]);
    chk("green", a_g, px[9:5]);
    chk("blue", a_b, px[14:10]);
  endtask

  task automatic tick(input bit fr, input bit rs);
    frame_ready = fr;
    reset = rs;
    @(posedge clk);
    #1;
    model_step(fr, rs);
    compare();
    if (track_b) begin
      if (b_prev && !b_hs) begin
        if (b_n < 2) b_fall[b_n] = k;
        b_n++;
      end
      b_prev = b_hs;
    end
  endtask

  task automatic run_until(input int h, input int v);
    int n;
    n = 0;
    while (!(mh[0] == h && mv[0] == v) && n < 2*P_HT*P_VT) begin
      tick(0, 0);
      n++;
    end
    if (!(mh[0] == h && mv[0] == v)) begin
      checks++; errors++;
      $error("FAIL run_until observed=(%0d,%0d) expected=(%0d,%0d)", mh[0], mv[0], h, v);
    end
  endtask

  task automatic arm_b();
    track_b = 1; b_prev = 1; b_n = 0;
    b_fall[0] = -1; b_fall[1] = -1;
  endtask

  initial begin
    reset = 1'b1;
    frame_ready = 1'b0;
    track_b = 0;
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 15'(i);
      mem1[i] = 15'($urandom);
    end
    mem1[5] = 15'h7FFF;

    // Reset, then real-timing horizontal sync on the default-parameter instance.
    repeat (3) tick(0, 1);
    arm_b();
    repeat (1700) tick(0, 0);
    chk("b_hs_fall0", b_fall[0], 659);
    chk("b_hs_fall1", b_fall[1], 1459);
    chk("no_swap_without_ready", a_sel, 0);
    track_b = 0;

    // Single pulse mid-frame: swap exactly at entry to vblank, then hold.
    run_until(0, 5);
    tick(1, 0);
    run_until(0, P_VA - 1);
    chk("sel_before_swap", a_sel, 0);
    run_until(0, P_VA);
    chk("swap_at_vblank", a_sel, 1);
    tick(0, 0);
    run_until(0, P_VA);
    chk("sel_held_next_frame", a_sel, 1);

    // Two pulses collapse into one toggle; a pulse on the swap cycle itself is consumed.
    run_until(0, 1);
    tick(1, 0);
    run_until(0, 10);
    tick(1, 0);
    run_until(0, P_VA);
    chk("two_pulses_one_toggle", a_sel, 0);
    run_until(P_HT - 1, P_VA - 1);
    tick(1, 0);
    chk("pulse_on_swap_cycle", a_sel, 1);
    tick(0, 0);
    run_until(0, P_VA);
    chk("pending_cleared", a_sel, 1);

    // Random frame_ready traffic over several frames.
    repeat (8 * P_HT * P_VT) tick($urandom_range(0, 199) == 0, 0);

    // One-cycle reset mid-frame; timing must restart from (0,0).
    run_until(12, 9);
    tick(0, 1);
    chk("reset_mid_sel", a_sel, 0);
    arm_b();
    repeat (1700) tick($urandom_range(0, 299) == 0, 0);
    chk("b_hs_fall0_after_reset", b_fall[0], 659);
    chk("b_hs_fall1_after_reset", b_fall[1], 1459);
    track_b = 0;
    repeat (4 * P_HT * P_VT) tick($urandom_range(0, 149) == 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Read-side partner of the graphics double-buffer writer.
- Generates 640x480@60 VGA timing on the pixel clock and reads the 240x160, 15-bit frame buffer being displayed.
- Doubles each source pixel horizontally and vertically into a centred 480x320 window; the border is black.
- Owns front/back buffer selection. Swaps at the start of vertical blank when the writer has flagged a completed frame.

Parameters:
- H_OFS, 80, first active column of the scaled window
- V_OFS, 80, first active line of the scaled window
- SRC_W, 240, source frame width in pixels
- SRC_H, 160, source frame height in lines
- READ_LAT, 1, frame-buffer read latency in cycles (rd_addr to rd_data)

Ports:
- clock  in  1  pixel clock (25.175 MHz)
- reset  in  1  synchronous, active-high
- frame_ready  in  1  one-cycle pulse from writer: back buffer holds a complete frame
- rd_sel  out  1  buffer being displayed (0 = buf0, 1 = buf1); writer targets ~rd_sel
- rd_en  out  1  read strobe, high only for window pixels
- rd_addr  out  17  frame-buffer word address
- rd_data  in  15  pixel from selected buffer, {B[14:10],G[9:5],R[4:0]}
- VGA_R, VGA_G, VGA_B  out  5 each  colour
- VGA_HS, VGA_VS  out  1 each  syncs, active low
- vblank  out  1  high while v_cnt >= 480 (undelayed)
- frame_start  out  1  one-cycle pulse when counters wrap to (0,0)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: h_cnt=0, v_cnt=0, rd_sel=0, pending=0, rd_en=0, rd_addr=0, RGB=0, HS=1, VS=1, vblank=0, frame_start=0, all pipeline stages cleared.
- Reset mid-frame: same values on the next edge; timing restarts at (0,0).
- Counters:
  - h_cnt counts 0..799 and wraps.
  - v_cnt increments on h wrap and counts 0..524.
- Raw timing:
  - active = h<640 && v<480
  - hs_n low for h in [656,752)
  - vs_n low for v in [490,492)
  - window = h in [H_OFS, H_OFS+2*SRC_W) && v in [V_OFS, V_OFS+2*SRC_H)
- Address generation (no multiplier):
  - line_base resets to 0 at frame start.
  - line_base += SRC_W after every odd window line, i.e. when (v-V_OFS)[0]==1, at the end of that line.
  - Pixel address = line_base + ((h-H_OFS)>>1). It increments every second window pixel.
  - Resulting address range is 0..38399 inclusive.
- Stage 0 (registered): rd_addr, rd_en=window.
  - Outside the window rd_addr holds its last value and rd_en=0.
- Data alignment: rd_data is valid READ_LAT cycles after stage 0. Window, active, hs_n and vs_n are delayed through an identical pipe.
- Output stage (registered):
  - RGB = rd_data fields if delayed window, else 0.
  - HS/VS = delayed hs_n/vs_n.
- Latency: counter state to pins = READ_LAT+2 cycles, identical for colour and syncs.
- Buffer swap:
  - frame_ready sets pending.
  - On the cycle the counters transition to (h=0, v=480): if pending or frame_ready, rd_sel toggles and pending clears.
  - frame_ready coincident with the swap cycle is consumed by that swap.
  - Multiple pulses before a swap collapse to one toggle.
  - rd_sel never changes outside that cycle, so no tearing.
- frame_start: asserted for the cycle counters equal (0,0). It is not delayed.

Test Plan:
- Reset release, READ_LAT=1 → first VGA_HS fall 659 cycles after first post-reset edge; HS period 800; VS low for exactly 1600 cycles; VS period 420000.
- Memory model returns data=addr[14:0] → screen (80,80)=0, (81,80)=0, (82,80)=1, (559,80)=239, (80,82)=240, (559,399)=38399; rd_en low at (79,80) and (560,80).
- Memory returns 0x7FFF everywhere → RGB=0 for all border pixels and blanking; RGB=31/31/31 for all 153600 window pixels per frame.
- frame_ready pulse at v=100 → rd_sel 0→1 exactly at (0,480); with no further pulse, rd_sel stays 1 through the next frame.
- Two pulses (v=10, v=300), then a pulse exactly on the (0,480) cycle of the next frame → one toggle per frame, pending=0 after each swap.
- Assert reset at v=300, h=400 for 1 cycle → next edge counters 0, rd_sel=0, HS=VS=1, RGB=0; timing matches the first scenario thereafter.
